arith_op_scheduler: RTL



---
 rtl/arith_op_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/arith_op_scheduler.sv
// Round-robin scheduler for two requesters sharing one adder / W-cycle shift-add multiplier.
// Optional ARITH_SCHED_STATS_EN adds a saturating completed-response counter (op_count).
module arith_op_scheduler #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_data,
`ifdef ARITH_SCHED_STATS_EN
  output logic [7:0]     op_count,
`endif
  output logic           busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, ADD, MUL, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant0, grant1;
  logic             accept, accept_id, accept_op;
  logic             id_r;
  logic [W-1:0]     a_r, b_r;
  logic [2*W-1:0]   acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             mul_done;

  // Contention goes to whichever requester was not served last.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = rst_n & (state == IDLE) & ena & grant0;
  assign req1_ready = rst_n & (state == IDLE) & ena & grant1;
  assign accept     = req0_ready | req1_ready;
  assign accept_id  = req1_ready;
  assign accept_op  = req1_ready ? req1_op : req0_op;

  assign mul_done = (cnt == CW'(W - 1));
  assign acc_nxt  = b_r[cnt] ? acc + ({{W{1'b0}}, a_r} << cnt) : acc;

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The response handshake completes even with ena low.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = accept_op ? MUL : ADD;
      ADD:  if (ena) state_nxt = RESP;
      MUL:  if (ena && mul_done) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      id_r       <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      acc        <= '0;
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= accept_id;
        id_r       <= accept_id;
        a_r        <= req1_ready ? req1_a : req0_a;
        b_r        <= req1_ready ? req1_b : req0_b;
        acc        <= '0;
        cnt        <= '0;
      end
      if (ena && state == ADD) begin
        rsp_data <= {{(W-1){1'b0}}, {1'b0, a_r} + {1'b0, b_r}};
        rsp_id   <= id_r;
      end
      if (ena && state == MUL) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (mul_done) begin
          rsp_data <= acc_nxt;
          rsp_id   <= id_r;
        end
      end
    end
  end

`ifdef ARITH_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= 8'd0;
    end else if (rsp_valid && rsp_ready && op_count != 8'hFF) begin
      op_count <= op_count + 8'd1;
    end
  end
`endif

endmodule
